blink_sequencer: RTL and testbench
==================================

Name: blink_sequencer

Overview:
- Controller that sequences the LED blink datapath: stores a programmable pattern of up to 8 steps (level + duration), and drives one blink output by stepping through the pattern on prescaled ticks.
- Sits between the ui_in command decode and uo_out[0] in the top level. It replaces the fixed free-running counter/blinker pair with a command-programmable scheduler.

Parameters:
- PRE_LSB_BITS, 8, number of prescaler low bits forced to ones; tick period = ({prescale_reg, PRE_LSB_BITS ones} + 1) cycles.
- RESET_PRESCALE, 8'd0, prescale_reg value after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  input  2  0=WRITE_STEP, 1=SET_LEN, 2=SET_PRESCALE, 3=CTRL.
- cmd_data  input  8  command payload.
- blink_out  output  1  LED drive, registered.
- busy  output  1  high in RUN or PAUSE.
- step_idx  output  3  index of current step, registered.
- done  output  1  one-cycle pulse at one-shot completion.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only at rising edges of clk.
- Reset state:
  - state=IDLE.
  - blink_out=0, busy=0, step_idx=0, done=0.
  - All 8 steps: level=0, dur=0.
  - last_idx=0, prescale_reg=RESET_PRESCALE.
  - Prescaler counter=0, remaining=0, oneshot=0.
- Commands:
  - WRITE_STEP: cmd_data[7:5] is the index, [4] the level, [3:0] the dur.
  - SET_LEN: last_idx=cmd_data[2:0]. The pattern runs steps 0..last_idx.
  - SET_PRESCALE: prescale_reg=cmd_data.
  - CTRL: [0]=run, [1]=oneshot, [2]=restart.
- Handshake:
  - cmd_ready=0 when state is RUN or PAUSE and cmd_op is 0 or 1.
  - cmd_ready=1 otherwise. It is combinational from state and cmd_op.
  - A stalled command is held by the sender.
- Duration: a step lasts D ticks, where D = (dur==0) ? 16 : dur.
- Prescaler:
  - Counts 0..P, where P={prescale_reg, PRE_LSB_BITS'hFF...}.
  - tick is asserted on the cycle counter==P; the counter then wraps to 0.
  - The counter runs only in RUN.
  - A new prescale value takes effect at the next wrap. If the counter is already above the new P, it runs to its maximum and wraps.
- State machine (IDLE, RUN, PAUSE):
  - IDLE, CTRL accepted with run=1 or restart=1: go to RUN with step_idx=0, remaining=D(step0), counter=0, oneshot latched from [1]. blink_out=level(step0) from the next cycle (latency 1).
  - RUN, on tick with remaining>1: remaining decrements.
  - RUN, on tick with remaining==1 and step_idx<last_idx: step_idx+1; load remaining and blink_out from the new step on the same edge.
  - RUN, on tick with remaining==1 and step_idx==last_idx, oneshot=0: wrap to step 0.
  - RUN, on tick with remaining==1 and step_idx==last_idx, oneshot=1: go to IDLE; blink_out=0, step_idx=0, and done pulses for 1 cycle.
  - RUN, CTRL with run=0 and restart=0: go to PAUSE. blink_out, step_idx, remaining and counter are all frozen.
  - PAUSE, CTRL with run=1: return to RUN and continue from the frozen counter.
  - PAUSE, CTRL with run=0: stay in PAUSE.
  - Any state, CTRL with restart=1: enter RUN at step 0 with the counter cleared. This has priority over run=0.
  - IDLE, CTRL with run=0 and restart=0: latch oneshot and stay in IDLE.
- Simultaneous tick and accepted CTRL on the same edge: the CTRL wins, and the tick is discarded.
- A last_idx change is allowed only outside RUN/PAUSE, so it cannot shorten a pattern that is in flight.
- Reset asserted mid-run: all registers return to reset values on that edge; blink_out is 0 the next cycle.
- done is never asserted in loop mode.

Test Plan:
- Reset, prescale=0 (256-cycle tick), step0={1,dur2}, step1={0,dur1}, SET_LEN 1, CTRL run → blink_out high 1 cycle after accept for 512 cycles, low 256 cycles, repeating; step_idx toggles 0/1.
- Same pattern, CTRL run|oneshot → high 512, low 256, then IDLE; done=1 exactly 768 cycles after the first RUN cycle; blink_out=0 and busy=0 afterward.
- While in RUN, present WRITE_STEP → cmd_ready=0 and the pattern is unchanged; present SET_PRESCALE 1 → accepted, and after the next wrap the tick period is 512 cycles.
- RUN, CTRL run=0 at cycle 100 of step0 → PAUSE with blink_out held at 1 for 1000 cycles; CTRL run=1 → step0 ends 412 cycles later.
- step0={1,dur0}, SET_LEN 0, oneshot → high for 16*256=4096 cycles, then done.
- rst_n=0 for 1 cycle mid-step → next cycle blink_out=0, state IDLE, step0 cleared, cmd_ready=1; restart while in RUN → step_idx=0 and counter=0 on the next cycle.

Source files
------------

// File: rtl/blink_sequencer.sv
// blink_sequencer: command-programmable 8-step blink pattern scheduler
// driving one registered LED output on prescaled ticks.
module blink_sequencer #(
    parameter int         PRE_LSB_BITS   = 8,
    parameter logic [7:0] RESET_PRESCALE = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       blink_out,
    output logic       busy,
    output logic [2:0] step_idx,
    output logic       done
);
    localparam int CW = 8 + PRE_LSB_BITS;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t        state_q;
    logic [7:0]    level_q;
    logic [3:0]    dur_q [8];
    logic [2:0]    last_q, step_q, step_d;
    logic [7:0]    pre_q, act_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    rem_q, rem_d;
    logic          os_q, blink_q, done_q;
    logic          acc, ctrl, tick, start, last_step;
    assign busy      = state_q != IDLE;
    assign cmd_ready = !(busy && !cmd_op[1]);
    assign acc       = cmd_valid && cmd_ready;
    assign ctrl      = acc && cmd_op == 2'd3;
    // act_q is the period in force; a new prescale is adopted only at a wrap
    assign tick      = state_q == RUN && cnt_q == {act_q, {PRE_LSB_BITS{1'b1}}};
    assign start     = ctrl && (cmd_data[2] || (state_q == IDLE && cmd_data[0]));
    assign last_step = step_q == last_q;
    assign step_d    = (start || last_step) ? 3'd0 : step_q + 3'd1;
    assign rem_d     = dur_q[step_d] == 4'd0 ? 5'd16 : {1'b0, dur_q[step_d]};
    assign blink_out = blink_q;
    assign step_idx  = step_q;
    assign done      = done_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            for (int i = 0; i < 8; i++) dur_q[i] <= '0;
            last_q  <= '0;
            step_q  <= '0;
            pre_q   <= RESET_PRESCALE;
            act_q   <= RESET_PRESCALE;
            cnt_q   <= '0;
            rem_q   <= '0;
            os_q    <= 1'b0;
            blink_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (acc && cmd_op == 2'd0) begin
                level_q[cmd_data[7:5]] <= cmd_data[4];
                dur_q[cmd_data[7:5]]   <= cmd_data[3:0];
            end
            if (acc && cmd_op == 2'd1) last_q <= cmd_data[2:0];
            if (acc && cmd_op == 2'd2) pre_q <= cmd_data;
            if (start) begin
                state_q <= RUN;
                step_q  <= step_d;
                rem_q   <= rem_d;
                cnt_q   <= '0;
                act_q   <= pre_q;
                blink_q <= level_q[step_d];
                os_q    <= cmd_data[1];
            end else if (ctrl) begin
                if (state_q == IDLE) os_q <= cmd_data[1];
                else if (!cmd_data[0]) state_q <= PAUSE;
                else if (state_q == PAUSE) state_q <= RUN;
                else begin
                    // CTRL in RUN swallows a coincident tick but the counter keeps time
                    cnt_q <= tick ? '0 : cnt_q + CW'(1);
                    act_q <= tick ? pre_q : act_q;
                end
            end else if (tick) begin
                cnt_q <= '0;
                act_q <= pre_q;
                if (rem_q > 5'd1) rem_q <= rem_q - 5'd1;
                else if (!last_step || !os_q) begin
                    step_q  <= step_d;
                    rem_q   <= rem_d;
                    blink_q <= level_q[step_d];
                end else begin
                    state_q <= IDLE;
                    step_q  <= '0;
                    rem_q   <= '0;
                    blink_q <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else if (state_q == RUN) cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: scoreboard bench; every accepted command pushes the
// output changes it must cause, and a negedge monitor pops and compares them.
module tb_blink_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, blink_out, busy, done;
    logic [2:0] step_idx;
    typedef struct {int c; int v;} evt_t;
    evt_t exp_q[$];
    int   cyc = 0, n_vec = 0, n_bad = 0, prev = 0;
    bit   mon_en = 1'b0;

    blink_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .blink_out(blink_out),
        .busy(busy), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pk(input bit d, input bit b, input int s, input bit bl);
        logic [2:0] s3;
        s3 = s[2:0];
        return {26'd0, d, b, s3, bl};
    endfunction

    task automatic expect_at(input int c, input bit bl, input int s, input bit b, input bit d);
        evt_t ev;
        ev.c = c;
        ev.v = pk(d, b, s, bl);
        exp_q.push_back(ev);
    endtask

    always @(negedge clk) begin
        int   cur;
        evt_t e;
        if (mon_en) begin
            cur = {26'd0, done, busy, step_idx, blink_out};
            if (cur != prev) begin
                if (exp_q.size() == 0) check("spurious_change", cur, prev);
                else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.c);
                    check("event_outputs", cur, e.v);
                end
                prev = cur;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d, output int t);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        #1;
        for (int i = 0; i < 8 && !cmd_ready; i++) begin
            @(negedge clk);
            #1;
        end
        check("cmd_accept", int'(cmd_ready), 1);
        t = cyc + 1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, r, p, q, s, e, x, t, st;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_blink", int'(blink_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step", int'(step_idx), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);
        prev   = {26'd0, done, busy, step_idx, blink_out};
        mon_en = 1'b1;
        // looping two-step pattern
        send(2'd0, 8'h12, t);
        send(2'd0, 8'h21, t);
        send(2'd1, 8'h01, t);
        send(2'd3, 8'h01, a);
        expect_at(a, 1, 0, 1, 0);
        expect_at(a + 512, 0, 1, 1, 0);
        expect_at(a + 768, 1, 0, 1, 0);
        expect_at(a + 1280, 0, 1, 1, 0);
        // pattern writes stall while running
        wait_to(a + 600);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_data  = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_write_step", int'(cmd_ready), 0);
            @(negedge clk);
        end
        cmd_op   = 2'd1;
        cmd_data = 8'h00;
        #1 check("stall_set_len", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        // restart from inside step1
        wait_to(a + 1350);
        send(2'd3, 8'h04, r);
        expect_at(r, 1, 0, 1, 0);
        expect_at(r + 512, 0, 1, 1, 0);
        expect_at(r + 768, 1, 0, 1, 0);
        // pause ~100 cycles into step0, hold 1000 cycles, resume
        st = r + 768;
        wait_to(st + 100);
        send(2'd3, 8'h00, p);
        wait_to(p + 1000);
        check("pause_blink", int'(blink_out), 1);
        check("pause_busy", int'(busy), 1);
        check("pause_step", int'(step_idx), 0);
        send(2'd3, 8'h01, q);
        e = q + 512 - (p - 1 - st);
        expect_at(e, 0, 1, 1, 0);
        expect_at(e + 256, 1, 0, 1, 0);
        wait_to(e + 300);
        check("pending_loop", exp_q.size(), 0);
        // reset mid-step
        @(negedge clk);
        rst_n = 1'b0;
        x = cyc + 1;
        expect_at(x, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmd_op = 2'd0;
        #1 check("ready_after_rst", int'(cmd_ready), 1);
        // cleared pattern: level 0, dur 0 -> 16 ticks
        send(2'd3, 8'h03, a);
        expect_at(a, 0, 0, 1, 0);
        expect_at(a + 4096, 0, 0, 0, 1);
        expect_at(a + 4097, 0, 0, 0, 0);
        wait_to(a + 4100);
        check("pending_cleared", exp_q.size(), 0);
        // dur 0 step, single-step oneshot
        send(2'd0, 8'h10, t);
        send(2'd1, 8'h00, t);
        send(2'd3, 8'h03, a);
        expect_at(a, 1, 0, 1, 0);
        expect_at(a + 4096, 0, 0, 0, 1);
        expect_at(a + 4097, 0, 0, 0, 0);
        wait_to(a + 4100);
        check("pending_dur0", exp_q.size(), 0);
        // two-step oneshot
        send(2'd0, 8'h12, t);
        send(2'd0, 8'h21, t);
        send(2'd1, 8'h01, t);
        send(2'd3, 8'h03, a);
        expect_at(a, 1, 0, 1, 0);
        expect_at(a + 512, 0, 1, 1, 0);
        expect_at(a + 768, 0, 0, 0, 1);
        expect_at(a + 769, 0, 0, 0, 0);
        wait_to(a + 800);
        check("oneshot_blink", int'(blink_out), 0);
        check("oneshot_busy", int'(busy), 0);
        check("pending_oneshot", exp_q.size(), 0);
        // prescale change mid-period applies from the next wrap
        send(2'd0, 8'h11, t);
        send(2'd3, 8'h01, a);
        expect_at(a, 1, 0, 1, 0);
        expect_at(a + 256, 0, 1, 1, 0);
        expect_at(a + 512, 1, 0, 1, 0);
        wait_to(a + 300);
        send(2'd2, 8'h01, s);
        check("prescale_window", int'(s < a + 512), 1);
        expect_at(a + 1024, 0, 1, 1, 0);
        expect_at(a + 1536, 1, 0, 1, 0);
        wait_to(a + 1600);
        check("pending_prescale", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
